// File: rtl/key_conditioner_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// rep_state_t : auto-repeat FSM states.
// Default cycle counts assume a 50 MHz CLOCK_50.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } rep_state_t;

  localparam int DEBOUNCE_20MS       = 1000000;
  localparam int REPEAT_DELAY_500MS  = 25000000;
  localparam int REPEAT_PERIOD_100MS = 5000000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle.
//   i_key_n   : raw active-low pushbutton (board side drives)
//   o_level   : debounced state, 1 = pressed
//   o_press   : one-cycle pulse on accepted press
//   o_release : one-cycle pulse on accepted release
//   o_repeat  : one-cycle auto-repeat pulse
//   o_event   : press or repeat, feeds game i_enter
// master = board/consumer side, slave = conditioner.
interface key_if;
  logic i_key_n;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_repeat;
  logic o_event;

  modport master (output i_key_n,
                  input  o_level, o_press, o_release, o_repeat, o_event);
  modport slave  (input  i_key_n,
                  output o_level, o_press, o_release, o_repeat, o_event);
endinterface

// File: rtl/key_conditioner_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (second flop)
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// Turns one bouncy active-low pushbutton into clean single-cycle events.
// Chain: 2-flop sync -> debounce counter -> level -> press/release pulses
// -> optional hold-to-repeat FSM.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   kif   : key_if.slave (raw key in, conditioned outputs)
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input logic clk,
  input logic reset,
  key_if.slave kif
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s2, k;
  logic [DW-1:0] dcnt;
  logic          level, press, release_p, repeat_p;
  logic          accept, rise, fall;

  // Sync flops reset to released so a key held through reset is seen
  // as a fresh press afterwards.
  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (kif.i_key_n),
    .q     (s2)
  );

  assign k = ~s2;

  // Change is accepted on the edge that would complete the stable run.
  assign accept = (k != level) && (dcnt == DEB_LAST);
  assign rise   = accept &  k;
  assign fall   = accept & ~k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt      <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
    end else begin
      // Pulses are registered alongside level so they coincide with
      // the first cycle of the new level.
      press     <= rise;
      release_p <= fall;
      if (k == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= k;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // ---------------- auto-repeat FSM ----------------
  rep_state_t    state, state_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic          repeat_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RELEASED;
      rcnt     <= '0;
      repeat_p <= 1'b0;
    end else begin
      state    <= state_nx;
      rcnt     <= rcnt_nx;
      repeat_p <= repeat_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rcnt_nx   = rcnt;
    repeat_nx = 1'b0;
    // An accepted release overrides any repeat due on the same edge.
    if (fall) begin
      state_nx = RELEASED;
      rcnt_nx  = '0;
    end else begin
      case (state)
        RELEASED: begin
          if (rise && REPEAT_EN) begin
            state_nx = HOLD_WAIT;
            rcnt_nx  = '0;
          end
        end
        HOLD_WAIT: begin
          if (rcnt == DLY_LAST) begin
            repeat_nx = 1'b1;
            rcnt_nx   = '0;
            state_nx  = REPEATING;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        REPEATING: begin
          if (rcnt == PER_LAST) begin
            repeat_nx = 1'b1;
            rcnt_nx   = '0;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        default: begin
          state_nx = RELEASED;
          rcnt_nx  = '0;
        end
      endcase
    end
  end

  assign kif.o_level   = level;
  assign kif.o_press   = press;
  assign kif.o_release = release_p;
  assign kif.o_repeat  = repeat_p;
  assign kif.o_event   = press | repeat_p;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench: a per-cycle vector table for clean press/release and
// bounce rejection, plus hand sequences for repeat timing, release in
// HOLD_WAIT, REPEAT_EN=0 and reset mid-hold.
module tb_key_conditioner;
  import key_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_if kif();
  key_if kif0();

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (.clk(clk), .reset(rst_n), .kif(kif));

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut0 (.clk(clk), .reset(rst_n), .kif(kif0));

  typedef struct {
    logic key;
    logic lvl;
    logic prs;
    logic rel;
    logic rep;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic k, input logic l, input logic p,
                     input logic r, input logic rp);
    vec_t v;
    v.key = k; v.lvl = l; v.prs = p; v.rel = r; v.rep = rp;
    tbl.push_back(v);
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic l, input logic p,
                          input logic r, input logic rp);
    chk({tag, ".level"},   32'(kif.o_level),   32'(l));
    chk({tag, ".press"},   32'(kif.o_press),   32'(p));
    chk({tag, ".release"}, 32'(kif.o_release), 32'(r));
    chk({tag, ".repeat"},  32'(kif.o_repeat),  32'(rp));
    chk({tag, ".event"},   32'(kif.o_event),   32'(p | rp));
  endtask

  // Steps until o_press is seen (bounded); n = number of edges taken.
  task automatic wait_press(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (kif.o_press) begin
        n = i;
        break;
      end
    end
    chk({tag, ".press_latency"}, 32'(n), 32'd6);
  endtask

  initial begin
    int n, evts, evts0;

    // Clean press then release: key sampled low from edge 0, accepted
    // after edge 5; sampled high from edge 10, release after edge 15.
    // Edge 15 is also where the HOLD_WAIT counter would have expired,
    // so the release must suppress that repeat.
    for (int i = 0; i < 20; i++)
      add((i < 10) ? 1'b0 : 1'b1, (i >= 5 && i < 15), (i == 5), (i == 15), 1'b0);
    // Bounce: low 3, high 1, low 3, then high -- never accepted.
    add(0,0,0,0,0); add(0,0,0,0,0); add(0,0,0,0,0); add(1,0,0,0,0);
    add(0,0,0,0,0); add(0,0,0,0,0); add(0,0,0,0,0);
    for (int i = 0; i < 7; i++) add(1,0,0,0,0);

    // ---------------- reset state ----------------
    kif.i_key_n  = 1'b1;
    kif0.i_key_n = 1'b1;
    rst_n = 1'b0;
    step(); step(); step();
    chk_outs("reset", 0, 0, 0, 0);
    chk("reset.state", 32'(dut.state), 32'(RELEASED));
    chk("reset.dut0_event", 32'(kif0.o_event), 32'd0);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      kif.i_key_n = tbl[i].key;
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rep);
    end

    // ---------------- hold repeat (both instances) ----------------
    kif.i_key_n  = 1'b0;
    kif0.i_key_n = 1'b0;
    wait_press("hold", n);
    evts  = 1;
    evts0 = kif0.o_event ? 1 : 0;
    for (int t = 1; t <= 45; t++) begin
      if (t == 33) begin
        // sampled at edge P+33 -> release accepted after edge P+38
        kif.i_key_n  = 1'b1;
        kif0.i_key_n = 1'b1;
      end
      step();
      chk($sformatf("hold.t%0d.repeat", t), 32'(kif.o_repeat),
          32'(t >= 10 && t <= 35 && (t % 5) == 0));
      chk($sformatf("hold.t%0d.release", t), 32'(kif.o_release), 32'(t == 38));
      chk($sformatf("hold0.t%0d.repeat", t), 32'(kif0.o_repeat), 32'd0);
      if (kif.o_event)  evts++;
      if (kif0.o_event) evts0++;
    end
    chk("hold.event_count", 32'(evts), 32'd7);
    chk("hold0.event_count", 32'(evts0), 32'd1);

    // ---------------- release during HOLD_WAIT ----------------
    kif.i_key_n = 1'b0;
    wait_press("hw", n);
    kif.i_key_n = 1'b1;   // sampled at P+1 -> release after edge P+6
    evts = 0;
    for (int t = 1; t <= 20; t++) begin
      step();
      chk($sformatf("hw.t%0d.release", t), 32'(kif.o_release), 32'(t == 6));
      chk($sformatf("hw.t%0d.level", t),   32'(kif.o_level),   32'(t < 6));
      if (kif.o_repeat) evts++;
    end
    chk("hw.repeat_count", 32'(evts), 32'd0);
    chk("hw.state", 32'(dut.state), 32'(RELEASED));

    // ---------------- reset mid-hold ----------------
    kif.i_key_n = 1'b0;
    wait_press("rst", n);
    for (int t = 1; t <= 12; t++) step();
    chk("rst.state_before", 32'(dut.state), 32'(REPEATING));
    #2 rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 0, 0, 0, 0);
    step(); step();
    chk_outs("rst.held", 0, 0, 0, 0);
    rst_n = 1'b1;         // key still held low
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("rst.e%0d.press", e), 32'(kif.o_press), 32'(e == 6));
      chk($sformatf("rst.e%0d.level", e), 32'(kif.o_level), 32'(e >= 6));
    end
    kif.i_key_n = 1'b1;
    for (int t = 0; t < 8; t++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions one raw DE1-SoC pushbutton (KEY[n], active-low, bouncy, asynchronous) into clean single-cycle events for the game logic.
- Sits between the board KEY pins and game's i_enter input; replaces the bare inversion of the key.
- Chain: two-flop synchroniser, debounce counter, debounced level, press/release edge pulses, optional hold-to-repeat pulses.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range >= 1.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while the key is held.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse; legal range >= 1.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; legal range >= 1.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  asynchronous, active-low reset.
- i_key_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- o_level  output  1  debounced key state, 1 = pressed.
- o_press  output  1  one-cycle pulse on the accepted press.
- o_release  output  1  one-cycle pulse on the accepted release.
- o_repeat  output  1  one-cycle pulse on each auto-repeat; stays 0 when REPEAT_EN = 0.
- o_event  output  1  o_press OR o_repeat; this output drives game i_enter.

Behaviour:
- Reset asserted:
  - Both sync flops go to 1 (released).
  - o_level, o_press, o_release, o_repeat and all counters go to 0.
  - FSM goes to RELEASED.
  - Takes effect immediately, with no clock required.
- Synchroniser: s1 <= i_key_n; s2 <= s1. Only s2 is used downstream; k = ~s2.
- Debounce counter:
  - dcnt width is $clog2(DEBOUNCE_CYCLES+1).
  - Each edge where k == o_level: dcnt <= 0.
  - Each edge where k != o_level and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - Each edge where k != o_level and dcnt == DEBOUNCE_CYCLES-1: o_level <= k and dcnt <= 0.
  - Any bounce back to the old level restarts the count from 0.
- Latency: i_key_n first sampled low at edge k means o_level rises after edge k+DEBOUNCE_CYCLES+1. Release is symmetric.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES sampled cycles never changes o_level.
- Edge pulses:
  - o_press is registered and high for exactly the cycle in which o_level first reads 1.
  - o_release is registered and high for exactly the cycle in which o_level first reads 0.
  - o_press and o_release are never high in the same cycle.
- Repeat FSM has three states: RELEASED, HOLD_WAIT, REPEATING.
  - RELEASED -> HOLD_WAIT on the accepted press, when REPEAT_EN = 1. rcnt <= 0.
  - HOLD_WAIT: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: o_repeat pulses, rcnt <= 0, go to REPEATING.
  - REPEATING: o_repeat pulses every REPEAT_PERIOD cycles.
  - Any state -> RELEASED in the cycle o_release is asserted. No repeat pulse occurs in that cycle or after it.
  - First repeat occurs REPEAT_DELAY cycles after o_press. Subsequent repeats occur every REPEAT_PERIOD cycles.
  - If REPEAT_EN = 0, the FSM stays in RELEASED.
  - rcnt width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). Counters never wrap in normal operation.
- o_event is combinational OR of o_press and o_repeat. o_press and o_repeat are never coincident by construction.
- Reset deasserted while the key is held:
  - Sync starts at released, so the key is treated as a fresh press.
  - o_press fires DEBOUNCE_CYCLES+2 edges after reset release. This is the intended behaviour.
- Reset asserted mid-debounce or mid-repeat: all progress is discarded and no pulse is emitted.

Decomposition:
- Shared package key_pkg holds:
  - typedef enum logic [1:0] {RELEASED, HOLD_WAIT, REPEATING} rep_state_t.
  - Default constants DEBOUNCE_20MS = 1000000, REPEAT_DELAY_500MS = 25000000, REPEAT_PERIOD_100MS = 5000000.
- One sub-module: bit_sync, a two-flop synchroniser.
  - Parameter RESET_VAL.
  - Asynchronous active-low reset.
  - Reused later for the SW inputs.

Test Plan:
- Use DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5 unless stated.
- Clean press: i_key_n 1 -> 0, first sampled at edge 10 -> o_level=1 and o_press=1 after edge 15; o_press lasts exactly 1 cycle.
- Bounce rejection: i_key_n low 3 cycles, high 1, low 3, then high -> o_level stays 0; o_press, o_release and o_event never assert.
- Hold repeat: press held 40 cycles after o_press -> o_repeat at +10, +15, +20, +25, +30, +35 cycles after o_press; o_event pulses 7 times total (press + 6 repeats).
- Release during HOLD_WAIT: release accepted 6 cycles after o_press -> o_release pulses once, o_repeat never asserts, FSM returns to RELEASED.
- REPEAT_EN=0: same 40-cycle hold -> exactly one o_event; o_repeat stuck at 0.
- Reset mid-hold: assert reset during REPEATING -> all outputs 0 immediately. With key still low, deassert reset -> o_press after DEBOUNCE_CYCLES+2 = 6 edges.
